// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a byte-wide memory.
// Port 0 is the CPU, port 1 the loader/debug port. Each access is 8 or 16 bits;
// 16-bit accesses become two byte cycles, little-endian (low byte at addr).
// Read data reaches pN_rdata on the clock edge that ends the ack cycle, so it
// is visible from the cycle after pN_ack.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int NPORT_IDX_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic                   p0_wide,
  input  logic [ADDR_W-1:0]      p0_addr,
  input  logic [15:0]            p0_wdata,
  output logic [15:0]            p0_rdata,
  output logic                   p0_ack,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic                   p1_wide,
  input  logic [ADDR_W-1:0]      p1_addr,
  input  logic [15:0]            p1_wdata,
  output logic [15:0]            p1_rdata,
  output logic                   p1_ack,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic                   busy,
  output logic [NPORT_IDX_W-1:0] owner
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

  localparam logic [NPORT_IDX_W-1:0] P0 = '0;
  localparam logic [NPORT_IDX_W-1:0] P1 = NPORT_IDX_W'(1);

  state_t                  state, state_nxt;
  logic                    we_q, wide_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W-1:0]       addr_hi;
  logic [15:0]             wdata_q;
  logic [NPORT_IDX_W-1:0]  owner_q;
  logic                    grant;
  logic                    win1;
`ifdef ARB_ROUND_ROBIN_EN
  logic                    last_q;
`endif

  // Merge one memory byte into a port's read register at a capture point:
  // ACC_HI takes the low byte of a wide read, DONE takes the final byte
  // (high byte when wide, the only byte with a zeroed upper half when narrow).
  function automatic logic [15:0] rd_capture(input logic [15:0] cur,
                                             input logic [7:0]  b,
                                             input state_t      st,
                                             input logic        wide);
    logic [15:0] r;
    r = cur;
    if (st == ACC_HI) begin
      r[7:0] = b;
    end else if (st == DONE) begin
      if (wide) r[15:8] = b;
      else      r      = {8'h00, b};
    end
    return r;
  endfunction

  assign addr_hi = addr_q + ADDR_W'(1);
  assign busy    = (state != IDLE);
  assign owner   = owner_q;

  // Arbitration: pick the winner among the ports requesting this cycle
  always_comb begin
    grant = p0_req | p1_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_req && p1_req) win1 = ~last_q;
    else                  win1 = p1_req;
`else
    win1 = p1_req & ~p0_req;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and memory-side / ack outputs
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_nxt = ACC_LO;
      end
      ACC_LO: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = we_q ? wdata_q[7:0] : 8'h00;
        state_nxt = wide_q ? ACC_HI : DONE;
      end
      ACC_HI: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_hi;
        mem_wdata = we_q ? wdata_q[15:8] : 8'h00;
        state_nxt = DONE;
      end
      DONE: begin
        p0_ack    = (owner_q == P0);
        p1_ack    = (owner_q == P1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request fields at grant; they stay frozen until the next grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= P0;
      we_q    <= 1'b0;
      wide_q  <= 1'b0;
    end else if (state == IDLE && grant) begin
      owner_q <= win1 ? P1 : P0;
      we_q    <= win1 ? p1_we   : p0_we;
      wide_q  <= win1 ? p1_wide : p0_wide;
    end
  end

  // Address and write data of the granted request (no reset needed: only
  // reach the memory bus in ACC_LO/ACC_HI, after a grant has loaded them)
  always_ff @(posedge clk) begin
    if (state == IDLE && grant) begin
      addr_q  <= win1 ? p1_addr  : p0_addr;
      wdata_q <= win1 ? p1_wdata : p0_wdata;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which port won last so contention alternates; starts at port 1
  // so port 0 wins the first contended grant
  always_ff @(posedge clk) begin
    if (!rst)                       last_q <= 1'b1;
    else if (state == IDLE && grant) last_q <= win1;
  end
`endif

  // Read data registers: only the owner's register moves, only on reads
  always_ff @(posedge clk) begin
    if (!rst) begin
      p0_rdata <= 16'h0000;
      p1_rdata <= 16'h0000;
    end else if (!we_q && (state == ACC_HI || state == DONE)) begin
      if (owner_q == P0) p0_rdata <= rd_capture(p0_rdata, mem_rdata, state, wide_q);
      if (owner_q == P1) p1_rdata <= rd_capture(p1_rdata, mem_rdata, state, wide_q);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a byte-wide memory model.
// Honours ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_wide;
  logic [15:0] p0_addr, p0_wdata, p0_rdata;
  logic        p0_ack;
  logic        p1_req, p1_we, p1_wide;
  logic [15:0] p1_addr, p1_wdata, p1_rdata;
  logic        p1_ack;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        owner;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'h0000;
  logic [7:0]  pl_data = 8'h00;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_wide(p0_wide), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_wide(p1_wide), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  // Byte memory: read data appears the cycle after the strobe; preload port for setup
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic set_port(input bit port, input logic req, input logic we, input logic wide,
                          input logic [15:0] addr, input logic [15:0] wdata);
    if (port == 1'b0) begin
      p0_req = req; p0_we = we; p0_wide = wide; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_wide = wide; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // Issue one request from an idle arbiter and observe six cycles.
  // hold=1: keep req up until the ack is seen; hold=0: drop req and scramble
  // the fields in the cycle after grant.
  task automatic run_txn(input bit port, input logic we, input logic wide,
                         input logic [15:0] addr, input logic [15:0] wdata, input bit hold,
                         output int lat, output int acks, output int other_acks, output int ens,
                         output logic [15:0] a1, output logic [15:0] a2, output logic own);
    logic ack_now, ack_oth;
    lat = -1; acks = 0; other_acks = 0; ens = 0; a1 = '0; a2 = '0; own = 1'b0;
    set_port(port, 1'b1, we, wide, addr, wdata);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      ack_now = (port == 1'b0) ? p0_ack : p1_ack;
      ack_oth = (port == 1'b0) ? p1_ack : p0_ack;
      if (k == 1) begin a1 = mem_addr; own = owner; end
      if (k == 2) a2 = mem_addr;
      if (mem_en) ens++;
      if (ack_now) begin acks++; if (lat < 0) lat = k; end
      if (ack_oth) other_acks++;
      if (k == 1 && !hold) set_port(port, 1'b0, ~we, ~wide, ~addr, ~wdata);
      if (hold && ack_now) set_port(port, 1'b0, we, wide, addr, wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (owner !== 1'b0) begin n_bad++; $display("FAIL rst_owner: got %b want 0", owner); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 00", mem_wdata); end
    n_cmp++; if ({p0_ack, p1_ack} !== 2'b00) begin n_bad++; $display("FAIL rst_ack: got %b want 00", {p0_ack, p1_ack}); end
    n_cmp++; if (p0_rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_p0_rdata: got %h want 0000", p0_rdata); end
    n_cmp++; if (p1_rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_p1_rdata: got %h want 0000", p1_rdata); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
  endtask

  task automatic test_narrow_read();
    int lat, acks, oth, ens; logic [15:0] a1, a2; logic own;
    run_txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, lat, acks, oth, ens, a1, a2, own);
    n_cmp++; if (p0_rdata !== 16'h00A5) begin n_bad++; $display("FAIL nrd_rdata: got %h want 00A5", p0_rdata); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL nrd_latency: got %0d want 2", lat); end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL nrd_ack_count: got %0d want 1", acks); end
    n_cmp++; if (ens !== 1) begin n_bad++; $display("FAIL nrd_mem_en_count: got %0d want 1", ens); end
    n_cmp++; if (a1 !== 16'h0010) begin n_bad++; $display("FAIL nrd_addr: got %h want 0010", a1); end
    n_cmp++; if (oth !== 0) begin n_bad++; $display("FAIL nrd_other_ack: got %0d want 0", oth); end
    n_cmp++; if (p1_rdata !== 16'h0000) begin n_bad++; $display("FAIL nrd_p1_rdata_held: got %h want 0000", p1_rdata); end
  endtask

  task automatic test_wide_write_read();
    int lat, acks, oth, ens; logic [15:0] a1, a2; logic own;
    run_txn(1'b1, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b1, lat, acks, oth, ens, a1, a2, own);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wwr_latency: got %0d want 3", lat); end
    n_cmp++; if (own !== 1'b1) begin n_bad++; $display("FAIL wwr_owner: got %b want 1", own); end
    n_cmp++; if (a2 !== 16'h0021) begin n_bad++; $display("FAIL wwr_addr_hi: got %h want 0021", a2); end
    n_cmp++; if (mem[16'h0020] !== 8'hEF) begin n_bad++; $display("FAIL wwr_byte_lo: got %h want EF", mem[16'h0020]); end
    n_cmp++; if (mem[16'h0021] !== 8'hBE) begin n_bad++; $display("FAIL wwr_byte_hi: got %h want BE", mem[16'h0021]); end
    n_cmp++; if (p1_rdata !== 16'h0000) begin n_bad++; $display("FAIL wwr_rdata_held: got %h want 0000", p1_rdata); end
    run_txn(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1, lat, acks, oth, ens, a1, a2, own);
    n_cmp++; if (p1_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL wrd_rdata: got %h want BEEF", p1_rdata); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wrd_latency: got %0d want 3", lat); end
    n_cmp++; if (ens !== 2) begin n_bad++; $display("FAIL wrd_mem_en_count: got %0d want 2", ens); end
    n_cmp++; if (p0_rdata !== 16'h00A5) begin n_bad++; $display("FAIL wrd_p0_rdata_held: got %h want 00A5", p0_rdata); end
  endtask

  task automatic test_wrap();
    int lat, acks, oth, ens; logic [15:0] a1, a2; logic own;
    poke(16'hFFFF, 8'h34);
    poke(16'h0000, 8'h12);
    run_txn(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, lat, acks, oth, ens, a1, a2, own);
    n_cmp++; if (a1 !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_addr_lo: got %h want FFFF", a1); end
    n_cmp++; if (a2 !== 16'h0000) begin n_bad++; $display("FAIL wrap_addr_hi: got %h want 0000", a2); end
    n_cmp++; if (p0_rdata !== 16'h1234) begin n_bad++; $display("FAIL wrap_rdata: got %h want 1234", p0_rdata); end
  endtask

  task automatic test_narrow_write();
    int lat, acks, oth, ens; logic [15:0] a1, a2; logic own;
    poke(16'h0031, 8'hCC);
    run_txn(1'b0, 1'b1, 1'b0, 16'h0030, 16'h7755, 1'b1, lat, acks, oth, ens, a1, a2, own);
    n_cmp++; if (mem[16'h0030] !== 8'h55) begin n_bad++; $display("FAIL nwr_byte: got %h want 55", mem[16'h0030]); end
    n_cmp++; if (mem[16'h0031] !== 8'hCC) begin n_bad++; $display("FAIL nwr_neighbour: got %h want CC", mem[16'h0031]); end
    n_cmp++; if (ens !== 1) begin n_bad++; $display("FAIL nwr_mem_en_count: got %0d want 1", ens); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL nwr_latency: got %0d want 2", lat); end
    n_cmp++; if (p0_rdata !== 16'h1234) begin n_bad++; $display("FAIL nwr_rdata_held: got %h want 1234", p0_rdata); end
    run_txn(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 1'b1, lat, acks, oth, ens, a1, a2, own);
    n_cmp++; if (p0_rdata !== 16'h0055) begin n_bad++; $display("FAIL nrd_upper_zero: got %h want 0055", p0_rdata); end
  endtask

  task automatic test_req_drop();
    int lat, acks, oth, ens; logic [15:0] a1, a2; logic own;
    run_txn(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, lat, acks, oth, ens, a1, a2, own);
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL drop_ack_count: got %0d want 1", acks); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL drop_latency: got %0d want 3", lat); end
    n_cmp++; if (p0_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL drop_rdata: got %h want BEEF", p0_rdata); end
    n_cmp++; if (mem[16'h0020] !== 8'hEF) begin n_bad++; $display("FAIL drop_no_write: got %h want EF", mem[16'h0020]); end
  endtask

  task automatic test_contention();
    int n = 0;
    int p1_cnt = 0;
    bit seq [0:15];
    bit exp_bit;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_cmp++; if (p0_rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_clears_rdata: got %h want 0000", p0_rdata); end
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    set_port(1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (p0_ack) begin seq[n] = 1'b0; n++; end
      if (p1_ack) begin seq[n] = 1'b1; n++; p1_cnt++; end
    end
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL cont_ack_total: got %0d want 5", n); end
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_bit = (i % 2 == 1);
`else
      exp_bit = 1'b0;
`endif
      n_cmp++; if (seq[i] !== exp_bit) begin n_bad++; $display("FAIL cont_grant_%0d: got %0d want %0d", i, seq[i], exp_bit); end
    end
`ifdef ARB_ROUND_ROBIN_EN
    n_cmp++; if (p1_cnt !== 2) begin n_bad++; $display("FAIL cont_p1_acks: got %0d want 2", p1_cnt); end
    n_cmp++; if (p1_rdata !== 16'h0055) begin n_bad++; $display("FAIL cont_p1_rdata: got %h want 0055", p1_rdata); end
`else
    n_cmp++; if (p1_cnt !== 0) begin n_bad++; $display("FAIL cont_p1_acks: got %0d want 0", p1_cnt); end
    n_cmp++; if (p1_rdata !== 16'h0000) begin n_bad++; $display("FAIL cont_p1_rdata: got %h want 0000", p1_rdata); end
`endif
    n_cmp++; if (p0_rdata !== 16'h00A5) begin n_bad++; $display("FAIL cont_p0_rdata: got %h want 00A5", p0_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int lat, acks, oth, ens; logic [15:0] a1, a2; logic own;
    set_port(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h1122);
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midop_busy_hi: got %b want 1", busy); end
    n_cmp++; if (mem_addr !== 16'h0041) begin n_bad++; $display("FAIL midop_addr_hi: got %h want 0041", mem_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midop_busy: got %b want 0", busy); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL midop_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (p0_ack !== 1'b0) begin n_bad++; $display("FAIL midop_ack: got %b want 0", p0_ack); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({mem_en, p0_ack, busy} !== 3'b000) begin n_bad++; $display("FAIL midop_after: got %b want 000", {mem_en, p0_ack, busy}); end
    run_txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, lat, acks, oth, ens, a1, a2, own);
    n_cmp++; if (p0_rdata !== 16'h00A5) begin n_bad++; $display("FAIL midop_recover_rdata: got %h want 00A5", p0_rdata); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL midop_recover_latency: got %0d want 2", lat); end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    poke(16'h0010, 8'hA5);
    test_narrow_read();
    test_wide_write_read();
    test_wrap();
    test_narrow_write();
    test_req_drop();
    test_contention();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory byte-address width.
REQ-002 SHALL have parameter NPORT_IDX_W, default 1, owner index width (two requesters).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports pN_req  input  1  access request, N = 0 (CPU) and 1 (loader/debug).
REQ-006 SHALL have ports pN_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports pN_wide  input  1  1 = 16-bit access, 0 = 8-bit access.
REQ-008 SHALL have ports pN_addr  input  16  byte address.
REQ-009 SHALL have ports pN_wdata  input  16  write data; only [7:0] is used when narrow.
REQ-010 SHALL have ports pN_rdata  output  16  read data; [15:8] = 0 when narrow.
REQ-011 SHALL have ports pN_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port mem_en  output  1  memory access strobe.
REQ-013 SHALL have port mem_we  output  1  memory write strobe.
REQ-014 SHALL have port mem_addr  output  16  memory byte address.
REQ-015 SHALL have port mem_wdata  output  8  memory write byte.
REQ-016 SHALL have port mem_rdata  input  8  read byte, valid one cycle after mem_en with mem_we = 0.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.
REQ-018 SHALL have port owner  output  1  index of the port currently served.

Function
REQ-019 SHALL implement the FSM states IDLE, ACC_LO, ACC_HI and DONE.
REQ-020 In IDLE with any pN_req = 1, SHALL latch the winner's we, wide, addr and wdata, set owner, and go to ACC_LO next cycle; in IDLE with no request, SHALL stay in IDLE.
REQ-021 In ACC_LO, SHALL drive mem_en = 1, mem_addr = addr and mem_we = we; on write, mem_wdata = wdata[7:0]; then go to ACC_HI if wide, else DONE.
REQ-022 In ACC_HI, SHALL drive mem_en = 1 and mem_addr = addr+1, wrapping 16'hFFFF to 16'h0000; on write, mem_wdata = wdata[15:8]; on read, capture mem_rdata into rdata[7:0]; then go to DONE.
REQ-023 In DONE, SHALL capture mem_rdata into rdata[15:8] (wide read) or rdata[7:0] (narrow read), pulse pN_ack of the owner for exactly one cycle, and return to IDLE.
REQ-024 SHALL drive mem_en = 0, mem_we = 0 in IDLE and DONE.
REQ-025 Latency: narrow access acks 2 cycles after the grant cycle; wide access acks 3 cycles after it; there is at least one IDLE cycle between transactions.
REQ-026 Byte order SHALL be little-endian: low byte at addr, high byte at addr+1.
REQ-027 pN_rdata SHALL update only for the owner, and only at the capture points; it SHALL hold its value otherwise.
REQ-028 Request fields SHALL be sampled only at grant; changes or deassertion of pN_req mid-transaction SHALL be ignored and the transaction SHALL complete and ack.
REQ-029 A requester still asserting req in the ack cycle SHALL be treated as a new request at the next IDLE.
REQ-030 The non-owner's request SHALL wait with no ack and no side effects.

Reset
REQ-031 On rst = 0 at a clock edge, the block SHALL go to IDLE with busy = 0, owner = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, pN_ack = 0, pN_rdata = 0, last-grant register = 1.
REQ-032 Reset mid-transaction SHALL abort with no ack, and with no memory strobe in the following cycle.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: with both requests in IDLE, the block SHALL grant the port not granted last; with a single request, that port wins.
REQ-034 Macro ARB_ROUND_ROBIN_EN undefined: with both requests, the block SHALL always grant port 0 (fixed priority), and SHALL omit the last-grant register.

Verification
REQ-035 Narrow read: p0 read of addr 16'h0010 holding 8'hA5 -> p0_rdata = 16'h00A5, p0_ack 2 cycles after grant, one mem_en pulse.
REQ-036 Wide write then wide read: p1 write of 16'hBEEF to 16'h0020 -> bytes EF@0020 and BE@0021; read back -> p1_rdata = 16'hBEEF, ack 3 cycles after grant.
REQ-037 Wrap: wide read at 16'hFFFF -> second mem_addr = 16'h0000; rdata = {mem[0000], mem[FFFF]}.
REQ-038 Contention with both reqs held: with ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1; without it, p0 is granted continually and p1 is never acked.
REQ-039 Reset mid-op: rst = 0 in ACC_HI of a wide write -> next cycle busy = 0, no ack, mem_en = 0; after release, p0 read completes normally.
REQ-040 Request drop: p0_req deasserted in ACC_LO -> transaction still completes with p0_ack = 1 once.
